// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        RELEASE,
        RUN
    } rs_state_t;

    // Width needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_n.sv
// N-flop synchroniser for a single asynchronous level; every stage clears on reset.
module sync_n #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release driven by a filtered PLL lock: domains come out of reset in
// index order once lock has been stable, and all re-enter reset on lock loss or soft reset.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int CHANNELS       = 3,
    parameter int HOLD_CYCLES    = 15,
    parameter int STAGGER_CYCLES = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int LOSS_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  locked_async,
    input  logic                  soft_reset_req,
    output logic [CHANNELS-1:0]   rst_out,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = clog2_min1(CNT_MAX);
    localparam int IDX_W   = clog2_min1(CHANNELS);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(CHANNELS - 1);

    logic locked_s;

    rs_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CHANNELS-1:0]   rst_q, rst_d;
    logic                  ready_q, ready_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  abort;

    sync_n #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (locked_async),
        .q     (locked_s)
    );

    // Losing lock only counts once at least one domain has been released.
    assign abort = (state_q != WAIT_LOCK) && !locked_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        loss_d  = loss_q;

        if (soft_reset_req || abort) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            if (abort && (loss_q != {LOSS_CNT_W{1'b1}})) begin
                loss_d = loss_q + 1'b1;
            end
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (!locked_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        cnt_d    = '0;
                        idx_d    = '0;
                        rst_d[0] = 1'b0;
                        if (CHANNELS == 1) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == STAGGER_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_q + 1'b1;
                        for (int i = 1; i < CHANNELS; i++) begin
                            if (i == int'(idx_q) + 1) begin
                                rst_d[i] = 1'b0;
                            end
                        end
                        if (idx_d == IDX_LAST) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    rst_d   = '0;
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '1;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            loss_q  <= loss_d;
        end
    end

    assign rst_out         = rst_q;
    assign ready           = ready_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default 3-channel instance and a 1-channel, 2-bit-counter
// instance share stimulus; a run-length reference model feeds a per-cycle expected queue.
module tb_reset_sequencer;

    localparam int HOLD = 15;
    localparam int STAG = 4;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       locked_async;
    logic       soft_reset_req;
    logic [2:0] rst_a;
    logic       ready_a;
    logic [7:0] loss_a;
    logic [0:0] rst_b;
    logic       ready_b;
    logic [1:0] loss_b;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    reset_sequencer dut_a (
        .clk             (clk),
        .reset           (reset),
        .locked_async    (locked_async),
        .soft_reset_req  (soft_reset_req),
        .rst_out         (rst_a),
        .ready           (ready_a),
        .lock_loss_count (loss_a)
    );

    reset_sequencer #(
        .CHANNELS   (1),
        .LOSS_CNT_W (2)
    ) dut_b (
        .clk             (clk),
        .reset           (reset),
        .locked_async    (locked_async),
        .soft_reset_req  (soft_reset_req),
        .rst_out         (rst_b),
        .ready           (ready_b),
        .lock_loss_count (loss_b)
    );

    // Reference model: k is the length of the current uninterrupted lock run as seen
    // after synchronisation; channel i is out of reset once k >= HOLD + i*STAG.
    logic [SYNC-1:0] hist;
    int k = 0;
    int la = 0;
    int lb = 0;

    always @(posedge clk) begin : model_p
        logic ls;
        logic abort_m;
        logic [2:0] er;
        if (reset) begin
            hist = '0;
            k = 0;
            la = 0;
            lb = 0;
        end else begin
            ls = hist[SYNC-1];
            abort_m = (k >= HOLD) && !ls;
            if (soft_reset_req || abort_m) begin
                k = 0;
                if (abort_m) begin
                    if (la < 255) la++;
                    if (lb < 3) lb++;
                end
            end else if (!ls) begin
                k = 0;
            end else if (k < 100000) begin
                k++;
            end
            hist = {hist[SYNC-2:0], locked_async};
        end
        for (int i = 0; i < 3; i++) er[i] = !(k >= HOLD + i * STAG);
        exp_q.push_back({er, (k >= HOLD + 2 * STAG), 8'(la), !(k >= HOLD), (k >= HOLD), 2'(lb)});
    end

    always @(negedge clk) begin : monitor_p
        logic [15:0] e;
        logic [15:0] act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {rst_a, ready_a, loss_a, rst_b, ready_b, loss_b};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL outputs @%0t got rst_a=%b rdy_a=%b loss_a=%0d rst_b=%b rdy_b=%b loss_b=%0d exp rst_a=%b rdy_a=%b loss_a=%0d rst_b=%b rdy_b=%b loss_b=%0d",
                         $time, act[15:13], act[12], act[11:4], act[3], act[2], act[1:0],
                         e[15:13], e[12], e[11:4], e[3], e[2], e[1:0]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic soft_pulse();
        soft_reset_req = 1'b1;
        tick(1);
        soft_reset_req = 1'b0;
    endtask

    // Posedges (from the next one) until rst_a[0] drops, or -1 on timeout.
    task automatic edges_to_rel0(input int limit, output int result);
        result = -1;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk);
            #1;
            if (!rst_a[0]) begin
                result = c;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic measure_first_release();
        int t0 = -1, t1 = -1, t2 = -1, tr = -1, tb = -1;
        locked_async = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (t0 < 0 && !rst_a[0]) t0 = c;
            if (t1 < 0 && !rst_a[1]) t1 = c;
            if (t2 < 0 && !rst_a[2]) t2 = c;
            if (tr < 0 && ready_a) tr = c;
            if (tb < 0 && ready_b && !rst_b[0]) tb = c;
        end
        @(negedge clk);
        chk("release_ch0", t0, 17);
        chk("release_ch1", t1, 21);
        chk("release_ch2", t2, 25);
        chk("ready_rise", tr, 25);
        chk("ready_rise_1ch", tb, 17);
    endtask

    initial begin : driver_p
        int r;
        reset = 1'b1;
        locked_async = 1'b0;
        soft_reset_req = 1'b0;
        tick(3);
        chk("reset_rst_out", int'(rst_a), 7);
        chk("reset_ready", int'(ready_a), 0);
        chk("reset_loss", int'(loss_a), 0);
        reset = 1'b0;
        tick(3);

        // Clean lock-up from reset.
        measure_first_release();

        // Lock drop in RUN.
        locked_async = 1'b0;
        r = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (rst_a == 3'b111 && !ready_a) begin
                r = c;
                break;
            end
        end
        @(negedge clk);
        chk("abort_latency", r, SYNC + 1);
        locked_async = 1'b1;
        tick(40);
        chk("loss_after_drop", int'(loss_a), 1);

        // Soft reset while channel 2 is still held.
        locked_async = 1'b0;
        tick(6);
        locked_async = 1'b1;
        tick(22);
        chk("pre_soft_rst_out", int'(rst_a), 3'b100);
        soft_pulse();
        chk("post_soft_rst_out", int'(rst_a), 7);
        edges_to_rel0(40, r);
        chk("soft_rerelease", r, 15);
        chk("soft_loss_unchanged", int'(loss_a), 2);

        // One-cycle glitch while still waiting for lock to settle.
        locked_async = 1'b0;
        tick(6);
        locked_async = 1'b1;
        tick(10);
        locked_async = 1'b0;
        tick(1);
        locked_async = 1'b1;
        edges_to_rel0(40, r);
        chk("glitch_release", r, 17);
        chk("glitch_no_loss", int'(loss_a), 3);

        // Master reset in the middle of the release sequence.
        locked_async = 1'b0;
        tick(6);
        locked_async = 1'b1;
        tick(19);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("midseq_reset_rst_out", int'(rst_a), 7);
        chk("midseq_reset_loss", int'(loss_a), 0);

        // Saturation of the narrow loss counter.
        for (int i = 0; i < 5; i++) begin
            locked_async = 1'b1;
            tick(30);
            locked_async = 1'b0;
            tick(4);
            chk("sat_loss_wide", int'(loss_a), i + 1);
            chk("sat_loss_narrow", int'(loss_b), (i + 1 > 3) ? 3 : i + 1);
        end

        // Lock loss and soft reset landing on the same cycle.
        locked_async = 1'b1;
        tick(30);
        locked_async = 1'b0;
        tick(SYNC);
        soft_pulse();
        tick(3);
        chk("coincident_loss_once", int'(loss_a), 6);

        // Randomised episodes, checked against the model.
        repeat (40) begin
            locked_async = 1'b1;
            tick($urandom_range(1, 45));
            case ($urandom_range(0, 7))
                0, 1: begin
                    locked_async = 1'b0;
                    tick(1);
                end
                2, 3: begin
                    locked_async = 1'b0;
                    tick($urandom_range(1, 6));
                end
                4: soft_pulse();
                5: begin
                    locked_async = 1'b0;
                    tick($urandom_range(0, 3));
                    soft_pulse();
                end
                6: begin
                    reset = 1'b1;
                    tick($urandom_range(1, 3));
                    reset = 1'b0;
                end
                default: tick(30);
            endcase
        end

        locked_async = 1'b0;
        tick(6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
